// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit FIFO and serialises each byte as a UART frame
// (start bit, 8 data bits LSB first, stop bit). Reset is synchronous, active-low.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [BAUD_W-1:0]  baud_cnt, baud_cnt_nxt;
    logic [2:0]         bit_idx, bit_idx_nxt;
    logic [7:0]         shift, shift_nxt;
    logic               tx_nxt;
    logic               rd_en_nxt;
    logic               busy_nxt;
    logic [CNT_W-1:0]   frame_count_nxt;
    logic               baud_end;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            tx          <= 1'b1;
            fifo_rd_en  <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            baud_cnt    <= baud_cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shift       <= shift_nxt;
            tx          <= tx_nxt;
            fifo_rd_en  <= rd_en_nxt;
            busy        <= busy_nxt;
            frame_count <= frame_count_nxt;
        end
    end

    assign baud_end = (baud_cnt == BAUD_LAST);

    // Next state; output values are computed for the next state so they register in step with it
    always_comb begin
        state_nxt       = state;
        baud_cnt_nxt    = baud_cnt;
        bit_idx_nxt     = bit_idx;
        shift_nxt       = shift;
        tx_nxt          = tx;
        rd_en_nxt       = 1'b0;
        frame_count_nxt = frame_count;

        case (state)
            IDLE: begin
                tx_nxt       = 1'b1;
                baud_cnt_nxt = '0;
                if (enable && !fifo_empty) begin
                    rd_en_nxt = 1'b1;
                    state_nxt = POP;
                end
            end
            POP: begin
                tx_nxt    = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                shift_nxt    = fifo_data;
                baud_cnt_nxt = '0;
                tx_nxt       = 1'b0;
                state_nxt    = START;
            end
            START: begin
                if (baud_end) begin
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                    tx_nxt       = shift[0];
                    state_nxt    = DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_nxt    = ^shift;
                        state_nxt = PARITY;
`else
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        tx_nxt      = shift[bit_idx_nxt];
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_cnt_nxt = '0;
                    tx_nxt       = 1'b1;
                    state_nxt    = STOP;
                end else begin
                    baud_cnt_nxt = baud_cnt + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                tx_nxt = 1'b1;
                if (baud_end) begin
                    baud_cnt_nxt    = '0;
                    frame_count_nxt = frame_count + CNT_W'(1);
                    state_nxt       = IDLE;
                end else begin
                    baud_cnt_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                tx_nxt       = 1'b1;
                baud_cnt_nxt = '0;
                state_nxt    = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-bit FIFO.
- Pops one byte at a time through the FIFO read port and serialises it on a UART TX line as 8N1: start bit, data LSB first, stop bit.
- Drains the FIFO continuously while enabled. Reports busy status and a count of frames sent.
- Sits between the FIFO and the board's serial pin.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 2
CNT_W, 16, width of the frame_count status counter

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
enable  input  1  allow new frames to start
fifo_empty  input  1  FIFO empty flag
fifo_data  input  8  FIFO data_out; registered, valid the cycle after a rd_en cycle
fifo_rd_en  output  1  FIFO read strobe, one-cycle pulse per byte
tx  output  1  serial line, idle high
busy  output  1  high from POP until the end of STOP
frame_count  output  CNT_W  frames fully transmitted since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset: on clk edge with rst_n=0, all of the following take effect and are visible the next cycle:
  - tx=1, fifo_rd_en=0, busy=0, frame_count=0
  - state=IDLE; baud and bit counters = 0
  - Reset mid-frame aborts the frame immediately and does not increment frame_count.
- All outputs are registered.
- States: IDLE, POP, LOAD, START, DATA, [PARITY], STOP.
- IDLE:
  - tx=1.
  - If enable=1 and fifo_empty=0: fifo_rd_en<=1, go to POP.
  - Otherwise stay in IDLE.
- POP:
  - One cycle with fifo_rd_en=1; the FIFO samples it at the end of this cycle.
  - fifo_rd_en<=0, go to LOAD.
- LOAD:
  - fifo_data is valid; shift register <= fifo_data.
  - Go to START.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles.
  - Then go to DATA with bit index 0.
- DATA:
  - tx = shift bit[index] for CLKS_PER_BIT cycles per bit, LSB first.
  - After bit 7, go to STOP (or PARITY if compiled in).
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the last cycle: frame_count <= frame_count+1, go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1; the bit ends when the counter equals CLKS_PER_BIT-1. Counter width is $clog2(CLKS_PER_BIT).
- Latency: the condition seen in IDLE at cycle N gives fifo_rd_en=1 at N+1 and the tx falling edge at N+3.
- Back-to-back frames: the idle gap between the end of one stop bit and the next start bit is exactly 3 cycles (IDLE, POP, LOAD).
- enable deasserted mid-frame: the current frame completes normally; no new pop.
- fifo_empty is sampled only in IDLE. The block never asserts fifo_rd_en while fifo_empty=1.
- busy=1 in POP, LOAD, START, DATA, PARITY and STOP.
- Frame length is 10 bit periods (11 with parity).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - After DATA bit 7, a PARITY state drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Then go to STOP.
  - Frame length is 11 bit periods.
- Undefined: no PARITY state; 8N1 only.

Test Plan:
1. Reset, FIFO empty, enable=1 for 100 cycles -> tx=1, fifo_rd_en never asserted, busy=0, frame_count=0.
2. CLKS_PER_BIT=4; FIFO holds 0xA5 -> fifo_rd_en is a 1-cycle pulse. tx = 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each held 4 cycles. frame_count=1 afterwards.
3. FIFO holds 0x00 then 0xFF -> two frames, exactly 3 tx-high cycles between the first stop bit end and the second start. frame_count=2. fifo_empty=1 at the end, then stays IDLE.
4. Drop enable during DATA bit 3 with 2 bytes queued -> the current frame finishes; no further fifo_rd_en; the second byte stays in the FIFO. Re-assert enable -> the second frame is sent.
5. Assert rst_n=0 during DATA bit 5 -> next cycle tx=1, busy=0, frame_count unchanged at 0.
6. With UART_TX_PARITY_EN and byte 0x07 -> parity bit 1 appears after bit 7. Frame is 44 cycles at CLKS_PER_BIT=4.
